// File: rtl/gaus_pkg.sv
// Shared types and constants for the Gaussian window sequencer and its
// position counter.
package gaus_pkg;

  localparam int PIXW    = 16;
  localparam int WORDW   = 64;
  localparam int WINROWS = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_SHIFT,
    S_LPAUSE,
    S_DONE
  } seqStateT;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gaus_pos_counter.sv
// Word/row position within the frame, with end-of-line and end-of-frame
// flags derived from the current count.
module gaus_pos_counter
  import gaus_pkg::*;
#(
  parameter int IMGW       = 2048,
  parameter int IMGH       = 2048,
  parameter int PIXPERWORD = WORDW / PIXW,
  parameter int CNTW       = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            advance,
  output logic [CNTW-1:0] wordCount,
  output logic [CNTW-1:0] rowCount,
  output logic            endOfLine,
  output logic            endOfFrame
);

  localparam int WORDSPERLINE = IMGW / PIXPERWORD;

  assign endOfLine  = (wordCount == CNTW'(WORDSPERLINE - 1));
  assign endOfFrame = endOfLine && (rowCount == CNTW'(IMGH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wordCount <= '0;
      rowCount  <= '0;
    end else if (clear) begin
      wordCount <= '0;
      rowCount  <= '0;
    end else if (advance) begin
      if (endOfLine) begin
        wordCount <= '0;
        rowCount  <= rowCount + 1'b1;
      end else begin
        wordCount <= wordCount + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gaus_window_sequencer.sv
// Frame controller for the 5-row window shifter: fetches words, strobes
// load/line-buffer push, shifts pixels out and flags complete windows.
module gaus_window_sequencer
  import gaus_pkg::*;
#(
  parameter int STARTADDRESS = 0,
  parameter int IMGW         = 2048,
  parameter int IMGH         = 2048,
  parameter int PIXPERWORD   = WORDW / PIXW,
  parameter int RDLAT        = 1,
  parameter int PAUSE        = 1,
  parameter int ADDRW        = 22,
  parameter int CNTW         = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             outReady,
  output logic             rdEn,
  output logic [ADDRW-1:0] rdAddr,
  output logic             loadEn,
  output logic             lineBufWe,
  output logic             shiftEn,
  output logic             winValid,
  output logic [CNTW-1:0]  rowCount,
  output logic [CNTW-1:0]  wordCount,
  output logic             busy,
  output logic             frameDone
);

  localparam int TMRW = $clog2(maxOf3(RDLAT, PIXPERWORD, PAUSE) + 1);

  seqStateT        state, nextState;
  logic [TMRW-1:0] timer;
  logic            shiftPhase;
  logic            lastShift, endOfLine, endOfFrame;
  logic            cntAdvance, cntClear;

  assign lastShift  = (timer == TMRW'(PIXPERWORD - 1));
  assign cntAdvance = (state == S_SHIFT) && outReady && lastShift && !endOfFrame && !abort;
  assign cntClear   = abort || (state == S_DONE);

  // shiftEn is a handshake with downstream, so it is qualified by outReady in
  // the same cycle; the registered phase bit carries the state.
  assign shiftEn  = shiftPhase && outReady;
  assign winValid = shiftEn && (rowCount >= CNTW'(WINROWS - 1)) && (wordCount != '0);

  gaus_pos_counter #(
    .IMGW      (IMGW),
    .IMGH      (IMGH),
    .PIXPERWORD(PIXPERWORD),
    .CNTW      (CNTW)
  ) uPosCounter (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (cntClear),
    .advance   (cntAdvance),
    .wordCount (wordCount),
    .rowCount  (rowCount),
    .endOfLine (endOfLine),
    .endOfFrame(endOfFrame)
  );

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    nextState = state;
    unique case (state)
      S_IDLE:   if (start) nextState = S_FETCH;
      S_FETCH:  nextState = S_WAIT;
      S_WAIT:   if (timer == TMRW'(RDLAT - 1)) nextState = S_LOAD;
      S_LOAD:   nextState = S_SHIFT;
      S_SHIFT: begin
        if (outReady && lastShift) begin
          if (endOfFrame)                   nextState = S_DONE;
          else if (endOfLine && PAUSE != 0) nextState = S_LPAUSE;
          else                              nextState = S_FETCH;
        end
      end
      S_LPAUSE: if (timer == TMRW'(PAUSE - 1)) nextState = S_FETCH;
      S_DONE:   nextState = S_IDLE;
      default:  nextState = S_IDLE;
    endcase
    if (abort) nextState = S_IDLE;
  end

  // NOTE: strobes are registered from nextState, so each output is a flop
  // that matches the state it is presented in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      rdAddr     <= ADDRW'(STARTADDRESS);
      rdEn       <= 1'b0;
      loadEn     <= 1'b0;
      lineBufWe  <= 1'b0;
      shiftPhase <= 1'b0;
      busy       <= 1'b0;
      frameDone  <= 1'b0;
    end else begin
      state <= nextState;
      if (nextState != state)
        timer <= '0;
      else if (state == S_WAIT || state == S_LPAUSE || (state == S_SHIFT && outReady))
        timer <= timer + 1'b1;

      if (cntClear)        rdAddr <= ADDRW'(STARTADDRESS);
      else if (cntAdvance) rdAddr <= rdAddr + 1'b1;

      rdEn       <= (nextState == S_FETCH);
      loadEn     <= (nextState == S_LOAD);
      lineBufWe  <= (nextState == S_LOAD);
      shiftPhase <= (nextState == S_SHIFT);
      busy       <= (nextState != S_IDLE);
      frameDone  <= (nextState == S_DONE);
    end
  end

endmodule
